prog_boot_ctrl: RTL and testbench
=================================

// Module: prog_boot_ctrl
// PURPOSE
//  Synthesizable boot controller for the single-cycle core. Streams a program image over a valid/ready port into instruction
//  memory, holds the core in reset while loading, then releases it. Counts run cycles and ends the run on core halt or on a
//  cycle-budget timeout. Replaces ad-hoc bench-side program loading and cycle limits with one reusable, parametrised block.
// PARAMETERS
//  DATA_W      32     word width; multiple of 8; address step = DATA_W/8 bytes
//  ADDR_W      32     memory address width (byte addresses)
//  BASE_ADDR   0      byte address of first program word
//  DEPTH       1024   max words per image (>=1)
//  RST_HOLD    4      cycles core_rst stays high after load completes (>=1)
//  MAX_CYCLES  512    run-cycle budget before timeout (>=1, < 2**CNT_W)
//  CNT_W       32     width of cyc_cnt
// PORTS
//  clk          in   1                   clock, all logic on posedge
//  rst          in   1                   synchronous, active-high reset
//  start        in   1                   begin load; honoured only in IDLE or DONE
//  s_valid      in   1                   program word valid
//  s_ready      out  1                   = (state==LOAD)
//  s_data       in   DATA_W              program word
//  s_last       in   1                   final word of image
//  mem_we       out  1                   imem write strobe (registered)
//  mem_addr     out  ADDR_W              imem byte address (registered)
//  mem_wdata    out  DATA_W              imem write data (registered)
//  core_rst     out  1                   reset to core; high except in RUN
//  core_halt    in   1                   core reports halt/ebreak
//  cksum_expect in   DATA_W              expected image checksum (used only with PROG_CKSUM_EN)
//  busy         out  1                   state is LOAD, HOLD or RUN
//  done         out  1                   sticky: run finished
//  timeout      out  1                   sticky: run ended on budget
//  ovf          out  1                   sticky: image hit DEPTH without s_last
//  cksum_err    out  1                   sticky: checksum mismatch
//  word_cnt     out  $clog2(DEPTH+1)     words accepted this load
//  cyc_cnt      out  CNT_W               completed RUN cycles
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; core_rst=1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; all status, counters=0.
//    Reset mid-operation abandons partial load/run; no write issued after the reset edge.
//  - States IDLE, LOAD, HOLD, RUN, DONE. start in IDLE/DONE -> LOAD next cycle; clears done/timeout/ovf/cksum_err,
//    word_cnt, cyc_cnt; address pointer to BASE_ADDR. start elsewhere ignored.
//  - LOAD: handshake = s_valid & s_ready. Handshake on word k -> next cycle mem_we=1, mem_addr=BASE_ADDR+k*(DATA_W/8),
//    mem_wdata=s_data; word_cnt=k+1. No handshake -> mem_we=0, pointer unchanged. Address wraps mod 2**ADDR_W.
//  - Handshake with s_last=1 -> HOLD. Handshake of DEPTH-th word with s_last=0 -> word written, ovf=1, HOLD.
//  - HOLD: core_rst=1 for exactly RST_HOLD cycles (includes cycle carrying the final mem_we), then RUN.
//  - RUN: core_rst=0; cyc_cnt increments each cycle. core_halt=1 -> DONE, done=1, cyc_cnt frozen (halt cycle not counted).
//    cyc_cnt reaching MAX_CYCLES without halt -> DONE, done=1, timeout=1. Halt on the final budget cycle: halt wins, timeout=0.
//  - DONE: core_rst=1; status and counters hold until start or rst.
// CONFIGURATION
//  PROG_CKSUM_EN defined: running sum (mod 2**DATA_W) of accepted words; on LOAD exit compare with cksum_expect;
//    mismatch -> DONE directly, cksum_err=1, done=1, core never released. Match -> HOLD as normal.
//  PROG_CKSUM_EN undefined: no accumulator; cksum_expect ignored; cksum_err tied 0.
// TESTING
//  1. rst=1 3 cycles, s_valid=1 -> core_rst=1, s_ready=0, mem_we=0, done=timeout=ovf=0, counters 0.
//  2. BASE_ADDR=0x0, start, 4 back-to-back words 0x00500093,0x00100113,0x002081B3,0x00100073 (last on 4th) -> mem_we at
//     addr 0x0,0x4,0x8,0xC one cycle after each handshake; word_cnt=4; core_rst falls exactly RST_HOLD=4 cycles later.
//  3. s_valid toggled 1,0,0,1,0,1 during LOAD -> writes only after handshake cycles; addresses contiguous 0x0,0x4,0x8.
//  4. core_halt=1 when cyc_cnt=10 -> done=1, timeout=0, cyc_cnt=10, core_rst=1 next cycle; start re-enters LOAD, flags clear.
//  5. MAX_CYCLES=512, halt never -> done=1, timeout=1, cyc_cnt=512; repeat with halt on cyc_cnt=511 -> timeout=0, cyc_cnt=511.
//  6. DEPTH=8, 9 words no s_last -> 8 writes, ovf=1, 9th not accepted; with PROG_CKSUM_EN and wrong cksum_expect ->
//     cksum_err=1, done=1, core_rst stays 1.

Source files
------------

// File: rtl/prog_boot_ctrl.sv
// rtl/prog_boot_ctrl.sv - program image loader / core reset sequencer / run-cycle watchdog (option: PROG_CKSUM_EN)
module prog_boot_ctrl #(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
    parameter int                 DEPTH      = 1024,
    parameter int                 RST_HOLD   = 4,
    parameter int                 MAX_CYCLES = 512,
    parameter int                 CNT_W      = 32,
    localparam int                WC_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    input  logic              core_halt,
    input  logic [DATA_W-1:0] cksum_expect,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              ovf,
    output logic              cksum_err,
    output logic [WC_W-1:0]   word_cnt,
    output logic [CNT_W-1:0]  cyc_cnt
);
    localparam int                HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [HC_W-1:0]   hold_cnt;
    logic              hs, last_word, start_ok, ck_fail;
    logic [CNT_W-1:0]  cyc_inc;

    assign s_ready   = (state == S_LOAD);
    assign core_rst  = (state != S_RUN);
    assign busy      = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);
    assign hs        = s_valid && s_ready;
    // Load ends on s_last or when the DEPTH-th word is taken regardless of s_last.
    assign last_word = s_last || (word_cnt == WC_W'(DEPTH - 1));
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign cyc_inc   = cyc_cnt + CNT_W'(1);

`ifdef PROG_CKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              ck_err_q;

    // Compare includes the word being accepted on the exit handshake.
    assign ck_fail   = hs && last_word && ((sum + s_data) != cksum_expect);
    assign cksum_err = ck_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum      <= '0;
            ck_err_q <= 1'b0;
        end else if (start_ok) begin
            sum      <= '0;
            ck_err_q <= 1'b0;
        end else begin
            if (hs)      sum      <= sum + s_data;
            if (ck_fail) ck_err_q <= 1'b1;
        end
    end
`else
    logic unused_cksum;

    assign ck_fail      = 1'b0;
    assign cksum_err    = 1'b0;
    assign unused_cksum = ^cksum_expect;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_LOAD;
            S_LOAD:         if (hs && last_word) state_nx = ck_fail ? S_DONE : S_HOLD;
            S_HOLD:         if (hold_cnt == HC_W'(RST_HOLD - 1)) state_nx = S_RUN;
            S_RUN:          if (core_halt || (cyc_inc == CNT_W'(MAX_CYCLES))) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            ptr       <= BASE_ADDR;
            hold_cnt  <= '0;
            word_cnt  <= '0;
            cyc_cnt   <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            mem_we <= hs;
            if (hs) begin
                mem_addr  <= ptr;
                mem_wdata <= s_data;
                ptr       <= ptr + STEP;
                word_cnt  <= word_cnt + WC_W'(1);
                if (last_word) begin
                    hold_cnt <= '0;
                    if (!s_last) ovf  <= 1'b1;
                    if (ck_fail) done <= 1'b1;
                end
            end
            if (start_ok) begin
                ptr      <= BASE_ADDR;
                word_cnt <= '0;
                cyc_cnt  <= '0;
                done     <= 1'b0;
                timeout  <= 1'b0;
                ovf      <= 1'b0;
            end
            if (state == S_HOLD) hold_cnt <= hold_cnt + HC_W'(1);
            // Halt cycle is not counted; halt on the last budget cycle beats timeout.
            if (state == S_RUN) begin
                if (core_halt) begin
                    done <= 1'b1;
                end else begin
                    cyc_cnt <= cyc_inc;
                    if (cyc_inc == CNT_W'(MAX_CYCLES)) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_boot_ctrl.sv
// tb/tb_prog_boot_ctrl.sv - scoreboard bench for prog_boot_ctrl with randomized image loads and runs
module tb_prog_boot_ctrl;
    localparam int DW = 32, AW = 32, DEPTH = 8, RH = 4, MAXC = 512, CW = 32;
    localparam int WCW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] BASE = 32'h0;

    logic           clk = 0, rst = 1, start = 0, s_valid = 0, s_last = 0, core_halt = 0;
    logic [DW-1:0]  s_data = '0, cksum_expect = '0;
    logic           s_ready, mem_we, core_rst, busy, done, timeout, ovf, cksum_err;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [WCW-1:0] word_cnt;
    logic [CW-1:0]  cyc_cnt;

    prog_boot_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH), .RST_HOLD(RH),
                     .MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_halt(core_halt), .cksum_expect(cksum_expect), .busy(busy),
        .done(done), .timeout(timeout), .ovf(ovf), .cksum_err(cksum_err), .word_cnt(word_cnt),
        .cyc_cnt(cyc_cnt));

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { bit to; bit ov; bit ck; int cyc; int wc; } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  ew;
    res_t er;
    int   total = 0, bad = 0;
    int   halt_at = 100000;
    int   cyc_no = 0, last_we_cyc = 0, run_j = 0;
    bit   done_q = 0, core_rst_q = 1;
    logic [31:0] fixed_w [4] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00100073};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Core model: raises halt during the run cycle whose index equals halt_at.
    always @(negedge clk) begin
        if (!core_rst) begin
            core_halt = (run_j == halt_at);
            run_j++;
        end else begin
            core_halt = 0;
            run_j = 0;
        end
    end

    // Monitor: pops expected writes and end-of-run results as the DUT presents them.
    always @(negedge clk) begin
        cyc_no++;
        if (mem_we) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                ew = wq.pop_front();
                chk("wr_addr", mem_addr, ew.a);
                chk("wr_data", mem_wdata, ew.d);
            end
            last_we_cyc = cyc_no;
        end
        if (core_rst_q && !core_rst) chk("release_delay", cyc_no - last_we_cyc, RH);
        core_rst_q = core_rst;
        if (done && !done_q) begin
            if (rq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                er = rq.pop_front();
                chk("timeout", timeout, er.to);
                chk("ovf", ovf, er.ov);
                chk("cksum_err", cksum_err, er.ck);
                chk("cyc_cnt", cyc_cnt, er.cyc);
                chk("word_cnt", word_cnt, er.wc);
                chk("done_core_rst", core_rst, 1);
                chk("done_busy", busy, 0);
                chk("writes_left", wq.size(), 0);
            end
        end
        done_q = done;
    end

    task automatic run_case(input int n, input bit use_last, input int h, input bit bad_ck,
                            input logic [15:0] vpat, input bit fixed);
        logic [DW-1:0] words[$];
        logic [DW-1:0] sum;
        int   acc, idx, k, guard;
        bit   v, ckf;
        res_t r;
        sum = '0;
        for (int i = 0; i < n; i++) words.push_back(fixed ? fixed_w[i] : $urandom());
        acc = (use_last && n <= DEPTH) ? n : DEPTH;
        for (int i = 0; i < acc; i++) begin
            sum += words[i];
            wq.push_back('{a: BASE + AW'(i * (DW / 8)), d: words[i]});
        end
`ifdef PROG_CKSUM_EN
        ckf = bad_ck;
`else
        ckf = 0;
`endif
        r.ck = ckf;
        r.ov = !(use_last && n <= DEPTH);
        r.wc = acc;
        if (ckf)           begin r.to = 0; r.cyc = 0;    end
        else if (h < MAXC) begin r.to = 0; r.cyc = h;    end
        else               begin r.to = 1; r.cyc = MAXC; end
        rq.push_back(r);
        halt_at = h;
        cksum_expect = sum + DW'(bad_ck);

        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("start_busy", busy, 1);
        chk("start_ready", s_ready, 1);
        chk("start_done_clr", done, 0);
        chk("start_flags_clr", {timeout, ovf, cksum_err}, 0);
        chk("start_cnt_clr", {word_cnt, cyc_cnt}, 0);

        idx = 0; k = 0; guard = 0;
        while (idx < n && guard < 200 && s_ready) begin
            guard++;
            v = (vpat != 16'h0) ? vpat[k % 16] : ($urandom_range(0, 99) < 70);
            k++;
            s_valid = v;
            s_data  = words[idx];
            s_last  = use_last && (idx == n - 1);
            @(posedge clk);
            #1;
            chk("we_follows_hs", mem_we, v);
            if (v) idx++;
            @(negedge clk);
        end
        s_valid = 0;
        s_last  = 0;
        chk("accepted", idx, acc);
        guard = 0;
        while (!done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!done) chk("done_wait", 0, 1);
        repeat (3) @(negedge clk);
        chk("done_sticky", done, 1);
        chk("core_rst_held", core_rst, 1);
    endtask

    initial begin
        rst = 1; s_valid = 1;
        repeat (3) @(negedge clk);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_ready", s_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_flags", {done, timeout, ovf, cksum_err, busy}, 0);
        chk("rst_counters", {word_cnt, cyc_cnt}, 0);
        chk("rst_addr", mem_addr, BASE);
        rst = 0; s_valid = 0;
        @(negedge clk);

        run_case(4, 1, 10, 0, 16'hFFFF, 1);
        run_case(3, 1, $urandom_range(0, 20), 0, 16'hFFE9, 0);
        run_case(2, 1, 100000, 0, 16'h0, 0);
        run_case(5, 1, MAXC - 1, 0, 16'h0, 0);
        run_case(9, 0, 3, 0, 16'hFFFF, 0);
        run_case(9, 0, 3, 1, 16'hFFFF, 0);
        for (int t = 0; t < 6; t++)
            run_case($urandom_range(1, DEPTH), 1, ($urandom_range(0, 3) == 0) ? 100000 : $urandom_range(0, 30),
                     $urandom_range(0, 3) == 0, 16'h0, 0);

        // Reset in the middle of a load: the two accepted words land, nothing after the reset edge.
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1; s_data = $urandom(); s_last = 0;
            wq.push_back('{a: BASE + AW'(i * 4), d: s_data});
            @(negedge clk);
        end
        s_valid = 0; rst = 1;
        @(negedge clk);
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_wc", word_cnt, 0);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("midrst_idle_we", mem_we, 0);
        chk("midrst_writes_left", wq.size(), 0);
        chk("results_left", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
